// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles the three buses around the instruction/data memory arbiter:
//   the core's instruction-fetch port, the core's data port, and the single
//   shared memory bus. Signal names carry the direction suffix as seen from
//   the arbiter (_i = into the arbiter, _o = out of the arbiter).
//
// Modports:
//   slave  - arbiter view: serves the two core ports, drives the memory bus.
//   master - environment view: core requesters plus the memory responder.
//
// Signals:
//   instr_req_i        1   fetch request, held until the port completes
//   instr_address_i    30  fetch word address [31:2]
//   instr_data_o       30  fetched instruction bits [31:2]
//   instr_blocking_n_o 1   0 = fetch pending (core IF stalls)
//   data_enabled_i     1   data access request, held until the port completes
//   data_address_i     30  data word address [31:2]
//   data_write_en_i    4   byte write enables, 0 = load
//   data_wdata_i       32  store data
//   data_rdata_o       32  load data
//   data_blocking_n_o  1   0 = data access pending (core MEM stalls)
//   mem_req_o          1   memory request, held until ack
//   mem_address_o      30  memory word address [31:2]
//   mem_write_en_o     4   memory byte enables, 0 = read
//   mem_wdata_o        32  memory write data
//   mem_rdata_i        32  memory read data, valid with ack
//   mem_ack_i          1   one-cycle completion strobe
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        instr_req_i;
  logic [29:0] instr_address_i;
  logic [29:0] instr_data_o;
  logic        instr_blocking_n_o;

  logic        data_enabled_i;
  logic [29:0] data_address_i;
  logic [3:0]  data_write_en_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_blocking_n_o;

  logic        mem_req_o;
  logic [29:0] mem_address_o;
  logic [3:0]  mem_write_en_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport slave (
    input  instr_req_i,
    input  instr_address_i,
    output instr_data_o,
    output instr_blocking_n_o,
    input  data_enabled_i,
    input  data_address_i,
    input  data_write_en_i,
    input  data_wdata_i,
    output data_rdata_o,
    output data_blocking_n_o,
    output mem_req_o,
    output mem_address_o,
    output mem_write_en_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_ack_i
  );

  modport master (
    output instr_req_i,
    output instr_address_i,
    input  instr_data_o,
    input  instr_blocking_n_o,
    output data_enabled_i,
    output data_address_i,
    output data_write_en_i,
    output data_wdata_i,
    input  data_rdata_o,
    input  data_blocking_n_o,
    input  mem_req_o,
    input  mem_address_o,
    input  mem_write_en_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_ack_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port memory bus between the core's instruction-fetch
//   port and its data port. The data port has fixed priority, but a
//   saturating starvation counter hands the bus to instruction fetch once
//   STARVE_LIMIT consecutive data grants have happened while a fetch waited.
//   Each port's blocking_n output lets the core's existing stall logic work
//   unchanged: it is low while the port's request is outstanding and high in
//   the single DONE cycle of that port (or whenever the port is not asking).
//
// Ports:
//   clk_i  - clock, all state on the rising edge
//   rst_i  - synchronous, active-high reset
//   bus    - mem_port_arbiter_if.slave (core instr/data ports + memory bus)
//
// Parameters:
//   STARVE_LIMIT - data grants allowed back-to-back while a fetch is waiting
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_e;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_LIMIT) begin
      starve_inc = CNT_LIMIT;
    end else begin
      starve_inc = cnt + CNT_ONE;
    end
  endfunction

  state_e           state_q,       state_d;
  logic [CNT_W-1:0] starve_cnt_q,  starve_cnt_d;
  logic             mem_req_q,     mem_req_d;
  logic [29:0]      mem_address_q, mem_address_d;
  logic [3:0]       mem_write_en_q, mem_write_en_d;
  logic [31:0]      mem_wdata_q,   mem_wdata_d;
  logic [29:0]      instr_data_q,  instr_data_d;
  logic [31:0]      data_rdata_q,  data_rdata_d;

  // Data wins unless a fetch is waiting and has already been passed over
  // STARVE_LIMIT times in a row.
  logic data_wins_s;
  assign data_wins_s = bus.data_enabled_i &
                       ~(bus.instr_req_i & (starve_cnt_q == CNT_LIMIT));

  // Next-state, arbitration and capture logic.
  always_comb begin
    state_d        = state_q;
    starve_cnt_d   = starve_cnt_q;
    mem_req_d      = mem_req_q;
    mem_address_d  = mem_address_q;
    mem_write_en_d = mem_write_en_q;
    mem_wdata_d    = mem_wdata_q;
    instr_data_d   = instr_data_q;
    data_rdata_d   = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (data_wins_s) begin
          mem_req_d      = 1'b1;
          mem_address_d  = bus.data_address_i;
          mem_write_en_d = bus.data_write_en_i;
          mem_wdata_d    = bus.data_wdata_i;
          state_d        = BUSY_D;
          // Only a data grant that overtakes a waiting fetch counts as starving it.
          if (bus.instr_req_i) begin
            starve_cnt_d = starve_inc(starve_cnt_q);
          end else begin
            starve_cnt_d = CNT_ZERO;
          end
        end else if (bus.instr_req_i) begin
          mem_req_d      = 1'b1;
          mem_address_d  = bus.instr_address_i;
          mem_write_en_d = 4'b0000;
          state_d        = BUSY_I;
          starve_cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY_I: begin
        if (bus.mem_ack_i) begin
          mem_req_d    = 1'b0;
          // Bits [1:0] of every 32-bit instruction are 2'b11, so they are dropped.
          instr_data_d = bus.mem_rdata_i[31:2];
          state_d      = DONE_I;
        end else begin
          state_d = BUSY_I;
        end
      end

      BUSY_D: begin
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = DONE_D;
          // A store leaves the last load result in place.
          if (mem_write_en_q == 4'b0000) begin
            data_rdata_d = bus.mem_rdata_i;
          end else begin
            data_rdata_d = data_rdata_q;
          end
        end else begin
          state_d = BUSY_D;
        end
      end

      // DONE lasts one cycle and never arbitrates, so a request still held
      // by the core during its DONE cycle is not reissued.
      DONE_I: begin
        state_d = IDLE;
      end

      DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      starve_cnt_q   <= CNT_ZERO;
      mem_req_q      <= 1'b0;
      mem_address_q  <= 30'd0;
      mem_write_en_q <= 4'b0000;
      mem_wdata_q    <= 32'd0;
      instr_data_q   <= 30'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      mem_req_q      <= mem_req_d;
      mem_address_q  <= mem_address_d;
      mem_write_en_q <= mem_write_en_d;
      mem_wdata_q    <= mem_wdata_d;
      instr_data_q   <= instr_data_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign bus.mem_req_o      = mem_req_q;
  assign bus.mem_address_o  = mem_address_q;
  assign bus.mem_write_en_o = mem_write_en_q;
  assign bus.mem_wdata_o    = mem_wdata_q;
  assign bus.instr_data_o   = instr_data_q;
  assign bus.data_rdata_o   = data_rdata_q;

  // Stall handshakes are combinational so the core sees its request stall
  // in the same cycle it raises it.
  assign bus.instr_blocking_n_o = ~bus.instr_req_i    | (state_q == DONE_I);
  assign bus.data_blocking_n_o  = ~bus.data_enabled_i | (state_q == DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (STARVE_LIMIT = 4). Inputs change and
// outputs are sampled on the falling clock edge. A small memory responder
// acks ack_wait cycles after it sees mem_req_o; ack_manual lets a test pulse
// the ack line by hand.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic ack_auto;
  logic ack_manual;
  logic auto_en;
  int   ack_wait;
  int   n_cmp;
  int   n_err;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.mem_ack_i = ack_auto | ack_manual;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: one-cycle ack after ack_wait wait cycles.
  initial begin
    int wcnt;
    wcnt     = 0;
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_auto) begin
        ack_auto = 1'b0;
        wcnt     = 0;
      end else if (auto_en && bus.mem_req_o) begin
        if (wcnt >= ack_wait) ack_auto = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Hard stop if something stalls forever.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [29:0] grant_addr [5];
  logic [31:0] cnt_at_4th;
  int          n_grant;
  logic        prev_req;
  bit          seen;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    auto_en = 1'b1;
    ack_wait = 0;
    ack_manual = 1'b0;
    bus.instr_req_i = 1'b0;
    bus.instr_address_i = 30'd0;
    bus.data_enabled_i = 1'b0;
    bus.data_address_i = 30'd0;
    bus.data_write_en_i = 4'b0000;
    bus.data_wdata_i = 32'd0;
    bus.mem_rdata_i = 32'd0;
    for (int i = 0; i < 5; i++) grant_addr[i] = 30'd0;

    // ---- reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check_val("rst_state",  32'(dut.state_q), 32'd0);
    check_val("rst_req",    32'(bus.mem_req_o), 32'd0);
    check_val("rst_we",     32'(bus.mem_write_en_o), 32'd0);
    check_val("rst_addr",   32'(bus.mem_address_o), 32'd0);
    check_val("rst_wdata",  bus.mem_wdata_o, 32'd0);
    check_val("rst_idata",  32'(bus.instr_data_o), 32'd0);
    check_val("rst_drdata", bus.data_rdata_o, 32'd0);
    check_val("rst_iblk",   32'(bus.instr_blocking_n_o), 32'd1);
    check_val("rst_dblk",   32'(bus.data_blocking_n_o), 32'd1);
    tick();

    // ---- instruction only, ack 2 cycles after mem_req
    bus.instr_address_i = 30'h10;
    bus.mem_rdata_i = 32'h0050_0093;
    ack_wait = 2;
    bus.instr_req_i = 1'b1;
    #1;
    check_val("i_blk_c0", 32'(bus.instr_blocking_n_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_val("i_blk", 32'(bus.instr_blocking_n_o), (i == 4) ? 32'd1 : 32'd0);
      if (i == 1) begin
        check_val("i_req",  32'(bus.mem_req_o), 32'd1);
        check_val("i_addr", 32'(bus.mem_address_o), 32'h10);
        check_val("i_we",   32'(bus.mem_write_en_o), 32'd0);
      end
    end
    check_val("i_data", 32'(bus.instr_data_o), 32'h0014_0024);
    bus.instr_req_i = 1'b0;
    tick();
    check_val("i_req_low", 32'(bus.mem_req_o), 32'd0);
    check_val("i_hold",    32'(bus.instr_data_o), 32'h0014_0024);

    // ---- store, immediate ack
    ack_wait = 0;
    bus.data_address_i = 30'h40;
    bus.data_write_en_i = 4'b0011;
    bus.data_wdata_i = 32'hDEAD_BEEF;
    bus.mem_rdata_i = 32'hCAFE_F00D;
    bus.data_enabled_i = 1'b1;
    #1;
    check_val("st_blk_c0", 32'(bus.data_blocking_n_o), 32'd0);
    tick();
    check_val("st_req",   32'(bus.mem_req_o), 32'd1);
    check_val("st_we",    32'(bus.mem_write_en_o), 32'h3);
    check_val("st_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    check_val("st_addr",  32'(bus.mem_address_o), 32'h40);
    check_val("st_blk_c1", 32'(bus.data_blocking_n_o), 32'd0);
    tick();
    check_val("st_blk_done", 32'(bus.data_blocking_n_o), 32'd1);
    check_val("st_rdata",    bus.data_rdata_o, 32'd0);
    check_val("st_req_low",  32'(bus.mem_req_o), 32'd0);
    bus.data_enabled_i = 1'b0;
    tick();

    // ---- load, immediate ack
    bus.data_address_i = 30'h41;
    bus.data_write_en_i = 4'b0000;
    bus.mem_rdata_i = 32'h1122_3344;
    bus.data_enabled_i = 1'b1;
    tick();
    check_val("ld_we",   32'(bus.mem_write_en_o), 32'd0);
    check_val("ld_addr", 32'(bus.mem_address_o), 32'h41);
    tick();
    check_val("ld_blk",   32'(bus.data_blocking_n_o), 32'd1);
    check_val("ld_rdata", bus.data_rdata_o, 32'h1122_3344);
    bus.data_enabled_i = 1'b0;
    tick();

    // ---- simultaneous requests, starve_cnt = 0: data first, then fetch
    bus.instr_address_i = 30'h20;
    bus.data_address_i = 30'h50;
    bus.mem_rdata_i = 32'hAABB_CCDD;
    bus.instr_req_i = 1'b1;
    bus.data_enabled_i = 1'b1;
    tick();
    check_val("sim_addr_d", 32'(bus.mem_address_o), 32'h50);
    tick();
    check_val("sim_dblk", 32'(bus.data_blocking_n_o), 32'd1);
    check_val("sim_iblk", 32'(bus.instr_blocking_n_o), 32'd0);
    check_val("sim_drd",  bus.data_rdata_o, 32'hAABB_CCDD);
    bus.data_enabled_i = 1'b0;
    tick();
    check_val("sim_idle_req", 32'(bus.mem_req_o), 32'd0);
    tick();
    check_val("sim_req_i",  32'(bus.mem_req_o), 32'd1);
    check_val("sim_addr_i", 32'(bus.mem_address_o), 32'h20);
    tick();
    check_val("sim_iblk_done", 32'(bus.instr_blocking_n_o), 32'd1);
    check_val("sim_idata",     32'(bus.instr_data_o), 32'h2AAE_F337);
    bus.instr_req_i = 1'b0;
    tick();

    // ---- starvation: both held high, 4 data grants then a fetch grant
    bus.instr_address_i = 30'h30;
    bus.data_address_i = 30'h60;
    bus.mem_rdata_i = 32'h0BAD_F00D;
    bus.instr_req_i = 1'b1;
    bus.data_enabled_i = 1'b1;
    n_grant = 0;
    cnt_at_4th = 32'hFFFF_FFFF;
    prev_req = 1'b0;
    for (int c = 0; c < 60 && n_grant < 5; c++) begin
      tick();
      if (bus.mem_req_o && !prev_req) begin
        grant_addr[n_grant] = bus.mem_address_o;
        if (n_grant == 3) cnt_at_4th = 32'(dut.starve_cnt_q);
        n_grant++;
      end
      prev_req = bus.mem_req_o;
    end
    check_val("stv_grants", 32'(n_grant), 32'd5);
    for (int i = 0; i < 5; i++)
      check_val("stv_order", 32'(grant_addr[i]), (i < 4) ? 32'h60 : 32'h30);
    check_val("stv_cnt4", cnt_at_4th, 32'd4);
    check_val("stv_cnt0", 32'(dut.starve_cnt_q), 32'd0);
    bus.data_enabled_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (bus.instr_blocking_n_o) seen = 1'b1;
    end
    check_val("stv_i_done", 32'(seen), 32'd1);
    bus.instr_req_i = 1'b0;
    tick();

    // ---- reset in BUSY_D, late ack afterwards
    auto_en = 1'b0;
    bus.data_address_i = 30'h70;
    bus.data_write_en_i = 4'b0000;
    bus.data_enabled_i = 1'b1;
    tick();
    check_val("rm_busy_req", 32'(bus.mem_req_o), 32'd1);
    rst = 1'b1;
    tick();
    check_val("rm_req",   32'(bus.mem_req_o), 32'd0);
    check_val("rm_state", 32'(dut.state_q), 32'd0);
    rst = 1'b0;
    bus.data_enabled_i = 1'b0;
    bus.mem_rdata_i = 32'h5555_AAAA;
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    check_val("rm_state2", 32'(dut.state_q), 32'd0);
    check_val("rm_req2",   32'(bus.mem_req_o), 32'd0);
    check_val("rm_rdata",  bus.data_rdata_o, 32'd0);

    // ---- stray ack in IDLE
    bus.mem_rdata_i = 32'h0000_1234;
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    check_val("sa_state", 32'(dut.state_q), 32'd0);
    check_val("sa_req",   32'(bus.mem_req_o), 32'd0);
    check_val("sa_idata", 32'(bus.instr_data_o), 32'd0);
    check_val("sa_drd",   bus.data_rdata_o, 32'd0);
    check_val("sa_addr",  32'(bus.mem_address_o), 32'd0);
    check_val("sa_iblk",  32'(bus.instr_blocking_n_o), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the core's instruction-fetch port and data port.
- Sits between the core's instr_cache_* / data_cache_* interfaces and the memory or bus wrapper.
- Drives each port's blocking_n so the core's existing IF and MEM stall logic works unchanged.
- Fixed data-port priority, bounded by an anti-starvation counter that protects instruction fetch.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits; after this many, the instruction port wins the next arbitration.

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
instr_req_i  input  1  instruction fetch request, held until the port completes
instr_address_i  input  30  [31:2] fetch word address
instr_data_o  output  30  [31:2] fetched instruction; bits [1:0] dropped because they are always 2'b11
instr_blocking_n_o  output  1  0 = fetch pending, core stalls
data_enabled_i  input  1  data access request, held until the port completes
data_address_i  input  30  [31:2] data word address
data_write_en_i  input  4  byte write enables; 0 = load
data_wdata_i  input  32  store data
data_rdata_o  output  32  load data
data_blocking_n_o  output  1  0 = data access pending
mem_req_o  output  1  memory request, held until ack
mem_address_o  output  30  [31:2] memory word address
mem_write_en_o  output  4  byte enables to memory; 0 = read
mem_wdata_o  output  32  memory write data
mem_rdata_i  input  32  memory read data, valid with ack
mem_ack_i  input  1  one-cycle completion strobe

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Reset values (rst_i high at an edge):
  - state = IDLE, mem_req_o = 0, mem_write_en_o = 0.
  - mem_address_o, mem_wdata_o, instr_data_o, data_rdata_o = 0.
  - starve_cnt = 0.
- Reset mid-transaction: the request is abandoned; mem_req_o is low the following cycle; a late mem_ack_i is ignored in IDLE.
- Blocking outputs are combinational:
  - instr_blocking_n_o = ~instr_req_i | (state == DONE_I).
  - data_blocking_n_o = ~data_enabled_i | (state == DONE_D).
- IDLE arbitration (registered):
  - Data only: grant data.
  - Instruction only: grant instruction.
  - Both requesting: grant instruction if starve_cnt == STARVE_LIMIT, otherwise grant data.
- On grant:
  - Latch address, write enables and wdata into the mem_* registers.
  - Set mem_req_o = 1 and move to BUSY_I or BUSY_D.
  - For an instruction grant, mem_write_en_o = 0.
- starve_cnt update rule:
  - Data grant while instr_req_i is high: increment, saturating at STARVE_LIMIT.
  - Any instruction grant: clear.
  - Data grant with no instruction request: clear.
- BUSY_x:
  - mem_* outputs are held stable until mem_ack_i.
  - Cycle with mem_ack_i = 1:
    - Next edge: mem_req_o = 0, state = DONE_x.
    - On a read, capture mem_rdata_i into instr_data_o (bits [31:2]) or data_rdata_o.
  - Store: data_rdata_o is not updated.
- DONE_x:
  - Exactly one cycle; the port's blocking_n is 1 and its data output is valid.
  - The next state is always IDLE; no arbitration happens in DONE, so the same held request is not reissued.
- Latency:
  - The request is seen in cycle t; mem_req_o rises at t+1.
  - With ack at t+1+k (k ≥ 0 wait cycles), DONE is at t+2+k.
  - The earliest completion is 3 cycles after the request.
- Requesters must hold their request and payload stable while blocking_n is 0.
  - If a request is dropped before grant, it is ignored.
  - If a request is dropped after grant, the memory access still completes and the DONE cycle is harmless.
- mem_ack_i outside BUSY states is ignored.
- instr_data_o and data_rdata_o hold their last captured value between accesses.

Test Plan:
- Instruction only:
  - Stimulus: instr_req_i = 1, addr 0x40 (word 0x10); memory acks 2 cycles after mem_req_o with rdata 0x00500093.
  - Response: mem_address_o = 0x10, mem_write_en_o = 0; instr_blocking_n_o low for 4 cycles then high for 1 cycle; instr_data_o = 0x00500093 >> 2.
- Store:
  - Stimulus: data_enabled_i = 1, write_en = 4'b0011, wdata 0xDEADBEEF, addr 0x100; immediate ack.
  - Response: mem_write_en_o = 0011, mem_wdata_o = 0xDEADBEEF, mem_address_o = 0x40; data_rdata_o unchanged; data_blocking_n_o high 3 cycles after request.
- Simultaneous requests, starve_cnt = 0:
  - Response: data is served first; instruction is granted in the IDLE after DONE_D; total 6 cycles with zero-wait ack.
- Starvation:
  - Stimulus: data_enabled_i re-requests every IDLE with instr_req_i held high, STARVE_LIMIT = 4.
  - Response: exactly 4 data grants, then an instruction grant, then starve_cnt = 0.
- Reset mid-access:
  - Stimulus: rst_i in BUSY_D, then mem_ack_i one cycle later.
  - Response: mem_req_o = 0 after the edge; state IDLE; the ack is ignored; data_rdata_o = 0.
- Stray ack:
  - Stimulus: mem_ack_i pulses in IDLE with rdata 0x1234.
  - Response: no output change; no state change.
